// File: rtl/adder_tree_pkg.sv
// Shared parameters and width helpers for the two-stage four-operand adder tree.
package adder_tree_pkg;

    localparam int NARROW_W_DEF = 4;
    localparam int WIDE_W_DEF   = 8;

    // Two additions of WIDE_W-bit-or-narrower operands need two carry bits.
    function automatic int sum_w(input int wide_w);
        return wide_w + 2;
    endfunction

endpackage

// File: rtl/pipe_add.sv
// One registered adder stage: (WIDTH+1)-bit sum of two unsigned inputs plus a valid bit.
module pipe_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             valid_q,
    output logic [WIDTH:0]   sum_q
);

    // Data loads every cycle; only valid_q qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_in;
            sum_q   <= {1'b0, x} + {1'b0, y};
        end
    end

endmodule

// File: rtl/adder_tree.sv
// Two-stage pipelined unsigned adder: sum3 = a + b + c + d, two cycles after sampling.
// Handshake: valid-only, no ready; out_valid qualifies sum3 and a result appears every cycle.
module adder_tree
    import adder_tree_pkg::*;
#(
    parameter int NARROW_W = NARROW_W_DEF,
    parameter int WIDE_W   = WIDE_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [NARROW_W-1:0]         a,
    input  logic [NARROW_W-1:0]         b,
    input  logic [WIDE_W-1:0]           c,
    input  logic [WIDE_W-1:0]           d,
    output logic                        out_valid,
    output logic [sum_w(WIDE_W)-1:0]    sum3
);

    localparam int SUM_W = sum_w(WIDE_W);

    logic              v1_ab;
    logic              v1_cd;
    logic [NARROW_W:0] sum1;
    logic [WIDE_W:0]   sum2;
    logic [WIDE_W:0]   sum1_x;
    logic [SUM_W-1:0]  sum3_q;
    logic              v2;

    pipe_add #(.WIDTH(NARROW_W)) u_add_ab (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (in_valid),
        .x        (a),
        .y        (b),
        .valid_q  (v1_ab),
        .sum_q    (sum1)
    );

    pipe_add #(.WIDTH(WIDE_W)) u_add_cd (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (in_valid),
        .x        (c),
        .y        (d),
        .valid_q  (v1_cd),
        .sum_q    (sum2)
    );

    assign sum1_x = (WIDE_W + 1)'(sum1);

    // Both first-stage valid bits carry the same registered in_valid.
    pipe_add #(.WIDTH(WIDE_W + 1)) u_add_final (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (v1_ab & v1_cd),
        .x        (sum1_x),
        .y        (sum2),
        .valid_q  (v2),
        .sum_q    (sum3_q)
    );

    assign out_valid = v2;
    assign sum3      = sum3_q;

endmodule

// File: tb/tb_adder_tree.sv
// Directed and random bench for adder_tree with a two-deep expected-result queue.
module tb_adder_tree;

    localparam int NW = 4;
    localparam int WW = 8;
    localparam int SW = WW + 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [NW-1:0] a;
    logic [NW-1:0] b;
    logic [WW-1:0] c;
    logic [WW-1:0] d;
    logic          out_valid;
    logic [SW-1:0] sum3;

    // {valid, sum} per driven cycle
    logic [SW:0] exp_q[$];
    int total;
    int bad;

    adder_tree dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .sum3      (sum3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; compare the output against the set driven two edges earlier.
    task automatic tick(input string tag);
        logic [SW:0] e;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(out_valid), 32'(e[SW]));
            chk({tag, "_sum"}, 32'(sum3), 32'(e[SW-1:0]));
            chk({tag, "_msb"}, 32'(sum3[SW-1]), 32'(e[SW-1]));
        end
    endtask

    task automatic drive(input string tag, input logic v, input logic [NW-1:0] ia,
                         input logic [NW-1:0] ib, input logic [WW-1:0] ic,
                         input logic [WW-1:0] id);
        logic [SW-1:0] s;
        in_valid = v;
        a = ia;
        b = ib;
        c = ic;
        d = id;
        s = SW'(ia) + SW'(ib) + SW'(ic) + SW'(id);
        exp_q.push_back({v, s});
        tick(tag);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        c = '0;
        d = '0;

        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum3), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, back to back
        drive("vec0", 1'b1, 4'd0, 4'd3, 8'd1, 8'd255);
        drive("vec1", 1'b1, 4'd10, 4'd13, 8'd9, 8'd10);
        drive("vec2", 1'b1, 4'd15, 4'd15, 8'd109, 8'd37);
        drive("vec3", 1'b1, 4'd0, 4'd9, 8'd45, 8'd45);
        drive("max", 1'b1, 4'd15, 4'd15, 8'd255, 8'd255);
        drive("zero", 1'b1, 4'd0, 4'd0, 8'd0, 8'd0);
        drive("msb_lo", 1'b1, 4'd15, 4'd15, 8'd200, 8'd200);

        // Valid gaps 1,0,1,1,0 with live data on the idle cycles
        drive("gap0", 1'b1, 4'd1, 4'd2, 8'd3, 8'd4);
        drive("gap1", 1'b0, 4'd7, 4'd7, 8'd77, 8'd77);
        drive("gap2", 1'b1, 4'd5, 4'd6, 8'd100, 8'd150);
        drive("gap3", 1'b1, 4'd14, 4'd3, 8'd250, 8'd1);
        drive("gap4", 1'b0, 4'd2, 4'd2, 8'd2, 8'd2);
        drive("flush0", 1'b0, 4'd0, 4'd0, 8'd0, 8'd0);
        drive("flush1", 1'b0, 4'd0, 4'd0, 8'd0, 8'd0);

        // Randomised back-to-back stream
        for (int i = 0; i < 1000; i++) begin
            drive("rand", 1'b1, NW'($urandom_range(0, 15)), NW'($urandom_range(0, 15)),
                  WW'($urandom_range(0, 255)), WW'($urandom_range(0, 255)));
        end

        // Mid-cycle reset with the random stream still in flight
        in_valid = 1'b1;
        a = 4'd9;
        b = 4'd9;
        c = 8'd99;
        d = 8'd99;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum3), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("inrst_valid", 32'(out_valid), 32'd0);
        chk("inrst_sum", 32'(sum3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        drive("post0", 1'b0, 4'd0, 4'd0, 8'd0, 8'd0);
        chk("post_first_valid", 32'(out_valid), 32'd0);
        drive("post1", 1'b0, 4'd0, 4'd0, 8'd0, 8'd0);
        drive("post2", 1'b1, 4'd15, 4'd15, 8'd255, 8'd255);
        drive("post3", 1'b0, 4'd0, 4'd0, 8'd0, 8'd0);
        drive("post4", 1'b0, 4'd0, 4'd0, 8'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
